usb_tx_arbiter: RTL and testbench
=================================

# usb_tx_arbiter

Round-robin packet arbiter sharing the single FPGA-to-host FT232H byte stream among up to 16 producers (ADC capture, status/telemetry, debug). It sits in the system clock domain, upstream of the FT232H controller's sys_axis sink and its async FIFO. It grants one producer at a time for a whole packet (tlast-delimited), caps burst length for fairness, and optionally tags each packet with a channel header byte so the host can demultiplex.

## Interface
- NUM_CHANNELS, 4: number of producer ports, 2..16.
- MAX_BURST, 256: maximum data beats per grant, 2..65535; longer packets are split.
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- s_tdata  input  NUM_CHANNELS*8  producer bytes, channel i at [8i+7:8i].
- s_tvalid  input  NUM_CHANNELS  producer valid.
- s_tlast  input  NUM_CHANNELS  producer end-of-packet.
- s_tready  output  NUM_CHANNELS  producer ready, at most one bit high.
- m_tdata  output  8  byte toward FT232H controller sink.
- m_tvalid  output  1  output valid.
- m_tlast  output  1  end of frame on output.
- m_tready  input  1  downstream ready.
- grant_id  output  4  index of current/last granted channel.
- busy  output  1  high in any state other than IDLE.

## Operation
- States: IDLE, HEADER, DATA.
- IDLE: s_tready=0, m_tvalid=0, m_tdata=0. If any s_tvalid, pick first requesting channel at or after rr_ptr (wrapping at NUM_CHANNELS-1 -> 0), register grant_id, clear burst counter, go to HEADER (header enabled) or DATA.
- HEADER: m_tvalid=1, m_tdata=HDR_START|grant_id for a fresh packet, HDR_CONT|grant_id if the previous grant to this channel ended by burst cap mid-packet; m_tlast=0; all s_tready=0. On m_tready -> DATA.
- DATA: combinational pass-through of granted channel: m_tdata=s_tdata[g], m_tvalid=s_tvalid[g], s_tready[g]=m_tready, other s_tready=0. m_tlast=s_tlast[g] OR (burst count==MAX_BURST-1).
- Beat = m_tvalid && m_tready. Each beat increments the 16-bit burst counter.
- Grant release: on beat with s_tlast[g] -> clear cont flag of g; on beat with counter==MAX_BURST-1 and !s_tlast[g] -> set cont flag of g. Either way rr_ptr <= g+1 (wrap), state -> IDLE.
- Granted channel dropping s_tvalid in DATA: hold grant, m_tvalid=0, no timeout.
- Non-granted requests wait; their s_tready stays 0 regardless of m_tready.
- Simultaneous requests: rotation order from rr_ptr decides; a channel releasing grant has lowest priority next arbitration.

## Timing
- Reset values: state IDLE, rr_ptr 0, grant_id 0, cont flags 0, counter 0, s_tready 0, m_tvalid 0, m_tlast 0, m_tdata 0, busy 0.
- Arbitration latency: s_tvalid rise in IDLE -> HEADER (m_tvalid) next cycle.
- Per-grant overhead: 1 IDLE cycle + 1 header beat; without header, 1 IDLE cycle.
- DATA path: zero-cycle latency, no register; m_tready->s_tready purely combinational.
- HEADER outputs stable while m_tvalid=1 and m_tready=0 (AXIS rule).
- Reset mid-packet: grant, cont flags and in-flight packet abandoned; next cycle IDLE with ptr 0.

## Configuration
- USB_TX_ARBITER_HEADER_EN defined: HEADER state present, every grant emits one header byte before data.
- Not defined: HEADER state, cont flags and header constants unused; IDLE goes straight to DATA; output carries raw data only; m_tlast behaviour unchanged.

## Structure
- ft232h_package gains: USB_TX_HDR_START = 8'hA0, USB_TX_HDR_CONT = 8'hB0, USB_TX_MAX_CHANNELS = 16, and the usb_tx_arbiter_state_t enum.
- One sub-module: rr_priority_select (combinational: request vector + pointer -> one-hot/index of winner, valid flag), reusable elsewhere.

## Test plan
- Single channel 2 sends 3-byte packet 11,22,33 (tlast on 33), m_tready=1 -> output A2,11,22,33; m_tlast only on 33; busy low after.
- Channels 0,1,3 request simultaneously, 1-byte packets, ptr 0 -> headers A0,A1,A3 order; second round starts at channel 0 after ptr wraps from 3+1=4 -> 0 (NUM_CHANNELS=4).
- MAX_BURST=4, channel 1 sends 6-byte packet while channel 0 idle -> A1,b0..b3 (tlast on b3), then B1,b4,b5 (tlast b5).
- m_tready toggled 1/0 every cycle during header and data -> no byte lost or duplicated, m_tdata stable while stalled.
- rst asserted for 1 cycle mid-DATA of channel 2 -> next cycle all outputs at reset values; subsequent requests from 0 and 2 serve 0 first.
- Build without USB_TX_ARBITER_HEADER_EN, channel 3 packet 55,66 -> output exactly 55,66, tlast on 66.

Source files
------------

// File: rtl/usb_tx_arbiter_pkg.sv
// Shared constants and types for the USB TX arbiter: header byte codes,
// channel limit, FSM state encoding and the round-robin pointer advance.
package usb_tx_arbiter_pkg;

  localparam logic [7:0] USB_TX_HDR_START    = 8'hA0;
  localparam logic [7:0] USB_TX_HDR_CONT     = 8'hB0;
  localparam int         USB_TX_MAX_CHANNELS = 16;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_HEADER = 2'd1,
    ARB_DATA   = 2'd2
  } usb_tx_arbiter_state_t;

  // Pointer to the channel after idx, wrapping at n-1.
  function automatic logic [3:0] next_ptr(input logic [3:0] idx, input int n);
    return (int'(idx) >= n - 1) ? 4'd0 : idx + 4'd1;
  endfunction

endpackage

// File: rtl/usb_tx_arbiter_rr_priority_select.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping at N-1 -> 0. Returns the winner index and a valid flag.
module rr_priority_select
  import usb_tx_arbiter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [3:0]   ptr,
  output logic [3:0]   idx,
  output logic         valid
);

  logic [N-1:0] rot;

  always_comb begin
    rot   = N'({req, req} >> ptr);
    idx   = '0;
    valid = 1'b0;
    for (int off = 0; off < N; off++) begin
      if (!valid && rot[off]) begin
        valid = 1'b1;
        idx   = (int'(ptr) + off >= N) ? 4'(int'(ptr) + off - N) : 4'(int'(ptr) + off);
      end
    end
  end

endmodule

// File: rtl/usb_tx_arbiter.sv
// Round-robin packet arbiter merging up to 16 byte streams onto one AXIS sink.
// Define USB_TX_ARBITER_HEADER_EN to prefix every grant with a channel header byte.
module usb_tx_arbiter
  import usb_tx_arbiter_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int MAX_BURST    = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CHANNELS*8-1:0] s_tdata,
  input  logic [NUM_CHANNELS-1:0]   s_tvalid,
  input  logic [NUM_CHANNELS-1:0]   s_tlast,
  output logic [NUM_CHANNELS-1:0]   s_tready,
  output logic [7:0]                m_tdata,
  output logic                      m_tvalid,
  output logic                      m_tlast,
  input  logic                      m_tready,
  output logic [3:0]                grant_id,
  output logic                      busy
);

  usb_tx_arbiter_state_t state;
  logic [3:0]  rr_ptr;
  logic [15:0] burst_cnt;
  logic [3:0]  sel_idx;
  logic        sel_valid;
  logic [7:0]  g_data;
  logic        g_valid;
  logic        g_last;
  logic        at_cap;
  logic        beat;

`ifdef USB_TX_ARBITER_HEADER_EN
  logic [NUM_CHANNELS-1:0] cont;
  logic [7:0]              hdr_byte;
  logic                    sel_cont;
`endif

  rr_priority_select #(.N(NUM_CHANNELS)) u_sel (
    .req   (s_tvalid),
    .ptr   (rr_ptr),
    .idx   (sel_idx),
    .valid (sel_valid)
  );

  always_comb begin
    g_data  = '0;
    g_valid = 1'b0;
    g_last  = 1'b0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (4'(i) == grant_id) begin
        g_data  = s_tdata[8*i +: 8];
        g_valid = s_tvalid[i];
        g_last  = s_tlast[i];
      end
    end
  end

`ifdef USB_TX_ARBITER_HEADER_EN
  always_comb begin
    sel_cont = 1'b0;
    for (int i = 0; i < NUM_CHANNELS; i++)
      if (4'(i) == sel_idx) sel_cont = cont[i];
  end
`endif

  assign at_cap = (burst_cnt == 16'(MAX_BURST - 1));
  assign beat   = m_tvalid && m_tready;
  assign busy   = (state != ARB_IDLE);

  // Data phase is a pure pass-through of the granted channel; no bubble.
  always_comb begin
    s_tready = '0;
    m_tdata  = '0;
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    case (state)
`ifdef USB_TX_ARBITER_HEADER_EN
      ARB_HEADER: begin
        m_tvalid = 1'b1;
        m_tdata  = hdr_byte;
      end
`endif
      ARB_DATA: begin
        m_tdata  = g_data;
        m_tvalid = g_valid;
        m_tlast  = g_last || at_cap;
        for (int i = 0; i < NUM_CHANNELS; i++)
          if (4'(i) == grant_id) s_tready[i] = m_tready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB_IDLE;
      rr_ptr    <= '0;
      grant_id  <= '0;
      burst_cnt <= '0;
`ifdef USB_TX_ARBITER_HEADER_EN
      cont      <= '0;
      hdr_byte  <= '0;
`endif
    end else begin
      case (state)
        ARB_IDLE: begin
          if (sel_valid) begin
            grant_id  <= sel_idx;
            burst_cnt <= '0;
`ifdef USB_TX_ARBITER_HEADER_EN
            hdr_byte  <= (sel_cont ? USB_TX_HDR_CONT : USB_TX_HDR_START) | {4'h0, sel_idx};
            state     <= ARB_HEADER;
`else
            state     <= ARB_DATA;
`endif
          end
        end
`ifdef USB_TX_ARBITER_HEADER_EN
        ARB_HEADER: begin
          if (m_tready) state <= ARB_DATA;
        end
`endif
        ARB_DATA: begin
          if (beat) begin
            burst_cnt <= burst_cnt + 16'd1;
            if (g_last || at_cap) begin
`ifdef USB_TX_ARBITER_HEADER_EN
              // A capped burst leaves the packet open; its next header says so.
              for (int i = 0; i < NUM_CHANNELS; i++)
                if (4'(i) == grant_id) cont[i] <= !g_last;
`endif
              rr_ptr <= next_ptr(grant_id, NUM_CHANNELS);
              state  <= ARB_IDLE;
            end
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_tx_arbiter.sv
// Self-checking bench for usb_tx_arbiter: queued producers, random stalls and a
// packet-level round-robin reference model of the expected output stream.
module tb_usb_tx_arbiter;

  localparam int NCH  = 4;
  localparam int MAXB = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NCH*8-1:0] s_tdata;
  logic [NCH-1:0]  s_tvalid;
  logic [NCH-1:0]  s_tlast;
  logic [NCH-1:0]  s_tready;
  logic [7:0]      m_tdata;
  logic            m_tvalid;
  logic            m_tlast;
  logic            m_tready;
  logic [3:0]      grant_id;
  logic            busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] src_q [NCH][$];
  logic [8:0] mdl_q [NCH][$];
  logic [8:0] obs_q [$];
  logic [8:0] exp_q [$];
  logic [NCH-1:0] pop_pend;
  int   tready_mode = 0;
  logic tog;
  int   stall_viol = 0;
  logic prev_stall;
  logic [7:0] prev_data;
  int   m_ptr = 0;
  logic [NCH-1:0] m_cont = '0;

  usb_tx_arbiter #(.NUM_CHANNELS(NCH), .MAX_BURST(MAXB)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .s_tlast  (s_tlast),
    .s_tready (s_tready),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tlast  (m_tlast),
    .m_tready (m_tready),
    .grant_id (grant_id),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Producers and sink ready, updated just after each rising edge.
  initial begin
    logic [8:0] e;
    s_tvalid = '0; s_tdata = '0; s_tlast = '0; m_tready = 1'b0; pop_pend = '0; tog = 1'b0;
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < NCH; i++)
        if (pop_pend[i] && src_q[i].size() > 0) src_q[i].delete(0);
      pop_pend = '0;
      for (int i = 0; i < NCH; i++) begin
        if (src_q[i].size() > 0) begin
          e = src_q[i][0];
          s_tvalid[i] = 1'b1; s_tdata[8*i +: 8] = e[7:0]; s_tlast[i] = e[8];
        end else begin
          s_tvalid[i] = 1'b0; s_tdata[8*i +: 8] = 8'h00; s_tlast[i] = 1'b0;
        end
      end
      tog = ~tog;
      case (tready_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = tog;
        default: m_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Handshake recorder, sampled mid-cycle.
  initial begin
    prev_stall = 1'b0; prev_data = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
        pop_pend   = '0;
      end else begin
        if (prev_stall && (!m_tvalid || m_tdata !== prev_data)) stall_viol++;
        for (int i = 0; i < NCH; i++)
          if (s_tvalid[i] && s_tready[i]) pop_pend[i] = 1'b1;
        if (m_tvalid && m_tready) obs_q.push_back({m_tlast, m_tdata});
        prev_stall = m_tvalid && !m_tready;
        prev_data  = m_tdata;
      end
    end
  end

  task automatic push_byte(input int ch, input logic [7:0] d, input logic last);
    src_q[ch].push_back({last, d});
    mdl_q[ch].push_back({last, d});
  endtask

  task automatic push_rand_pkt(input int ch, input int len);
    for (int k = 0; k < len; k++) push_byte(ch, 8'($urandom), (k == len - 1));
  endtask

  // Expected stream: whole-burst round robin over channels with queued data.
  task automatic model_build();
    int ch, n;
    logic [8:0] e;
    bit done, any;
    any = 1'b1;
    while (any) begin
      any = 1'b0;
      for (int i = 0; i < NCH; i++) if (mdl_q[i].size() > 0) any = 1'b1;
      if (any) begin
        ch = -1;
        for (int k = 0; k < NCH; k++) begin
          int c;
          c = (m_ptr + k) % NCH;
          if (ch < 0 && mdl_q[c].size() > 0) ch = c;
        end
`ifdef USB_TX_ARBITER_HEADER_EN
        exp_q.push_back({1'b0, (m_cont[ch] ? 8'hB0 : 8'hA0) | 8'(ch)});
`endif
        n = 0; done = 1'b0;
        while (!done) begin
          e = mdl_q[ch][0];
          mdl_q[ch].delete(0);
          n++;
          if (e[8]) begin
            exp_q.push_back(e); m_cont[ch] = 1'b0; done = 1'b1;
          end else if (n == MAXB) begin
            exp_q.push_back({1'b1, e[7:0]}); m_cont[ch] = 1'b1; done = 1'b1;
          end else begin
            exp_q.push_back(e);
          end
        end
        m_ptr = (ch + 1) % NCH;
      end
    end
  endtask

  task automatic drain(output bit ok);
    int cyc;
    bit empty;
    ok = 1'b0; cyc = 0;
    while (cyc < 3000 && !ok) begin
      @(negedge clk); #1;
      empty = 1'b1;
      for (int i = 0; i < NCH; i++) if (src_q[i].size() > 0) empty = 1'b0;
      if (empty && !busy && obs_q.size() >= exp_q.size()) ok = 1'b1;
      cyc++;
    end
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic start_scenario();
    @(negedge clk); #1;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic reset_pulse();
    @(negedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    m_ptr = 0; m_cont = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_m_tvalid: got %b want 0", m_tvalid); end
    n_checks++; if (m_tlast !== 1'b0) begin n_fail++; $display("FAIL reset_m_tlast: got %b want 0", m_tlast); end
    n_checks++; if (m_tdata !== 8'h00) begin n_fail++; $display("FAIL reset_m_tdata: got %h want 00", m_tdata); end
    n_checks++; if (s_tready !== 4'h0) begin n_fail++; $display("FAIL reset_s_tready: got %b want 0000", s_tready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (grant_id !== 4'h0) begin n_fail++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
    #1 rst = 1'b0;
    m_ptr = 0; m_cont = '0;
  endtask

  task automatic test_single();
    bit ok;
    tready_mode = 0;
    start_scenario();
    push_byte(2, 8'h11, 1'b0); push_byte(2, 8'h22, 1'b0); push_byte(2, 8'h33, 1'b1);
    model_build();
    drain(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL single_drain: timeout obs=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL single_len: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      n_checks++;
      if (obs_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL single_beat %0d: got %h want %h", k, obs_q[k], exp_q[k]); end
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b want 0", busy); end
    n_checks++; if (grant_id !== 4'd2) begin n_fail++; $display("FAIL single_grant_id: got %0d want 2", grant_id); end
    start_scenario();
    push_byte(3, 8'h55, 1'b0); push_byte(3, 8'h66, 1'b1);
    model_build();
    drain(ok);
    n_checks++; if (!ok || obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL ch3_len: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      n_checks++;
      if (obs_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL ch3_beat %0d: got %h want %h", k, obs_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_simultaneous();
    bit ok;
    reset_pulse();
    tready_mode = 0;
    start_scenario();
    for (int r = 0; r < 2; r++) begin
      push_byte(0, 8'(8'h10 + r), 1'b1);
      push_byte(1, 8'(8'h20 + r), 1'b1);
      push_byte(3, 8'(8'h30 + r), 1'b1);
    end
    model_build();
    drain(ok);
    n_checks++; if (!ok || obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL simul_len: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      n_checks++;
      if (obs_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL simul_beat %0d: got %h want %h", k, obs_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_burst_split();
    bit ok;
    tready_mode = 0;
    start_scenario();
    for (int k = 0; k < 6; k++) push_byte(1, 8'(8'hC0 + k), (k == 5));
    model_build();
    drain(ok);
    n_checks++; if (!ok || obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL burst_len: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      n_checks++;
      if (obs_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL burst_beat %0d: got %h want %h", k, obs_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_stall();
    bit ok;
    tready_mode = 1;
    stall_viol = 0;
    start_scenario();
    push_rand_pkt(0, $urandom_range(1, 6));
    push_rand_pkt(2, $urandom_range(3, 7));
    push_rand_pkt(0, $urandom_range(1, 6));
    model_build();
    drain(ok);
    n_checks++; if (!ok || obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL stall_len: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      n_checks++;
      if (obs_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL stall_beat %0d: got %h want %h", k, obs_q[k], exp_q[k]); end
    end
    n_checks++; if (stall_viol != 0) begin n_fail++; $display("FAIL stall_stable: got %0d changes want 0", stall_viol); end
    tready_mode = 0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int cyc;
    tready_mode = 0;
    start_scenario();
    for (int k = 0; k < 6; k++) push_byte(2, 8'(8'hD0 + k), (k == 5));
    cyc = 0;
    while (obs_q.size() < 3 && cyc < 200) begin @(negedge clk); cyc++; end
    n_checks++; if (obs_q.size() < 3) begin n_fail++; $display("FAIL rstmid_start: got %0d beats want 3", obs_q.size()); end
    #1;
    rst = 1'b1;
    for (int i = 0; i < NCH; i++) begin src_q[i].delete(); mdl_q[i].delete(); end
    pop_pend = '0;
    @(posedge clk); #2;
    n_checks++; if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || m_tdata !== 8'h00) begin n_fail++; $display("FAIL rstmid_out: got v=%b l=%b d=%h want 0/0/00", m_tvalid, m_tlast, m_tdata); end
    n_checks++; if (s_tready !== 4'h0 || busy !== 1'b0 || grant_id !== 4'h0) begin n_fail++; $display("FAIL rstmid_ctl: got rdy=%b busy=%b gid=%0d want 0/0/0", s_tready, busy, grant_id); end
    rst = 1'b0;
    m_ptr = 0; m_cont = '0;
    start_scenario();
    push_byte(2, 8'hE0, 1'b0); push_byte(2, 8'hE1, 1'b1);
    push_byte(0, 8'hF0, 1'b0); push_byte(0, 8'hF1, 1'b1);
    model_build();
    drain(ok);
    n_checks++; if (!ok || obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rstmid_len: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      n_checks++;
      if (obs_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL rstmid_beat %0d: got %h want %h", k, obs_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_random();
    bit ok, any;
    for (int it = 0; it < 20; it++) begin
      tready_mode = $urandom_range(0, 2);
      stall_viol = 0;
      start_scenario();
      any = 1'b0;
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 1) == 1 || (c == NCH - 1 && !any)) begin
          any = 1'b1;
          for (int p = 0; p < int'($urandom_range(1, 2)); p++) push_rand_pkt(c, $urandom_range(1, 7));
        end
      end
      model_build();
      drain(ok);
      n_checks++; if (!ok || obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand%0d_len: got %0d want %0d", it, obs_q.size(), exp_q.size()); end
      for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
        n_checks++;
        if (obs_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL rand%0d_beat %0d: got %h want %h", it, k, obs_q[k], exp_q[k]); end
      end
      n_checks++; if (stall_viol != 0) begin n_fail++; $display("FAIL rand%0d_stable: got %0d changes want 0", it, stall_viol); end
    end
    tready_mode = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_burst_split();
    test_stall();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
